// File: rtl/add_result_buffer.sv
// ---------------------------------------------------------------------------
// add_result_buffer
//
// Small synchronous FIFO that captures results from a carry-lookahead adder
// ({cout, sum}) and hands them to a downstream consumer through a
// valid/ready handshake.
//
// Besides buffering, the block keeps two pieces of bookkeeping:
//   carry_count : saturating count of accepted results whose carry-out was 1
//   overflow    : sticky flag, set when a valid result arrived but could not
//                 be accepted (FIFO full and the head was not being retired)
//
// Ports
//   clock        in   single clock, all state updates on its rising edge
//   reset        in   asynchronous, active-high reset
//   in_valid     in   in_sum/in_cout carry a valid adder result this cycle
//   in_sum       in   adder sum, WIDTH bits
//   in_cout      in   adder carry-out
//   in_ready     out  a push this cycle will be accepted (combinational)
//   out_valid    out  out_data holds the head entry
//   out_ready    in   consumer takes the head entry this cycle
//   out_data     out  head entry {cout, sum}, WIDTH+1 bits
//   level        out  current number of stored entries, 0..DEPTH
//   carry_count  out  saturating count of accepted entries with cout=1
//   overflow     out  sticky: a valid result was dropped
//
// Parameters
//   WIDTH  sum width (default 64)
//   DEPTH  number of FIFO entries, a power of two >= 2 (default 4)
// ---------------------------------------------------------------------------
module add_result_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_cout,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                carry_count,
  output logic                       overflow
);

  // -------------------------------------------------------------------------
  // Local sizes
  // -------------------------------------------------------------------------
  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int LW = PW + 1;          // level width, must represent DEPTH
  localparam int EW = WIDTH + 1;       // entry width {cout, sum}

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [15:0]   CARRY_MAX  = 16'hFFFF;

  // -------------------------------------------------------------------------
  // Storage and pointers
  // -------------------------------------------------------------------------
  // DEPTH is a power of two, so the PW-bit pointers wrap modulo DEPTH by
  // plain binary overflow; fullness comes from level, not from the pointers.
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic push;
  logic pop;
  logic drop;

  // A full buffer can still take a new result when the head leaves in the
  // same cycle: the freed slot is the one the write pointer lands on.
  assign in_ready  = (level < FULL_LEVEL) || out_ready;
  assign out_valid = (level != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  // Head is always read from storage; a result is never forwarded straight
  // from in_* to out_*, which gives the one-cycle write-to-read latency.
  assign out_data = mem[rd_ptr];

  // -------------------------------------------------------------------------
  // Next-state computation
  // -------------------------------------------------------------------------
  logic [LW-1:0] level_nxt;
  logic [15:0]   carry_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;   // both or neither: count unchanged
    endcase
  end

  always_comb begin
    carry_nxt = carry_count;
    if (push && in_cout && (carry_count != CARRY_MAX)) begin
      carry_nxt = carry_count + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Control state: pointers, level, statistics
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      carry_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level       <= level_nxt;
      carry_count <= carry_nxt;
      if (drop) begin
        overflow <= 1'b1;           // sticky until reset
      end
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  // NOTE: the data array is deliberately left out of reset; out_data is only
  // meaningful while out_valid=1, and leaving it unreset lets it map onto
  // plain flops or a register file without reset wiring.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_cout, in_sum};
    end
  end

endmodule
